// File: rtl/vga_fb_arbiter_if.sv
// Writer-side handshake bundle for vga_fb_arbiter.
//   master : drawing/game-logic writer (drives wr_req/wr_addr/wr_data, sees wr_ready)
//   slave  : arbiter (sees the request, drives wr_ready)
// wr_addr is the linear pixel address y*640+x; wr_addr/wr_data must be held
// stable while wr_req is high until the cycle in which wr_ready is also high.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous framebuffer RAM between
// display scanout and a writer. Scanout owns the RAM during the prefetch
// window (LEAD cycles ahead of the active area); the writer is served in all
// other cycles through a valid/ready port.
//
// Ports:
//   vga_clock, rst_n   pixel clock, asynchronous active-low reset
//   hcount, vcount     timing generator counters
//   wr                 writer port (vga_fb_arbiter_if.slave): wr_req, wr_ready,
//                      wr_addr, wr_data; wr_ready is combinational
//   mem_addr/we/wdata  registered RAM command
//   mem_rdata          RAM read data, valid RAM_LAT cycles after mem_addr
//   pixel_out          registered pixel, aligned to hcount/vcount, 0 in blanking
//   frame_tick         one-cycle pulse after the edge at vcount==V_END, hcount==0
//   synced             scanout is frame-aligned (first vcount==0 seen)
//
// Optional build macro VGA_FB_VBLANK_ONLY_WRITE_EN: writes are accepted only
// during vertical blanking (tear-free drawing).
module vga_fb_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 19,
  parameter int H_START = 144,
  parameter int H_END   = 784,
  parameter int V_START = 35,
  parameter int V_END   = 515,
  parameter int RAM_LAT = 1
) (
  input  logic              vga_clock,
  input  logic              rst_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  vga_fb_arbiter_if.slave   wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              frame_tick,
  output logic              synced
);

  // One cycle to register the address, RAM_LAT in the RAM, one to register the pixel.
  localparam int LEAD   = RAM_LAT + 2;
  localparam int PIPE_W = LEAD - 1;

  localparam logic [9:0] F_H_LO = 10'(H_START - LEAD);
  localparam logic [9:0] F_H_HI = 10'(H_END - LEAD);
  localparam logic [9:0] V_LO   = 10'(V_START);
  localparam logic [9:0] V_HI   = 10'(V_END);

  typedef enum logic {UNSYNC, SYNC} sync_state_t;

  sync_state_t       state, state_nxt;
  logic              fetch;
  logic              wr_fire;
  logic [ADDR_W-1:0] rd_ptr;
  logic [PIPE_W-1:0] vld_pipe;

  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) state <= UNSYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    synced    = (state == SYNC);
    if (state == UNSYNC && vcount == '0) state_nxt = SYNC;
  end

  always_comb begin
    fetch = synced
         && (vcount >= V_LO)   && (vcount < V_HI)
         && (hcount >= F_H_LO) && (hcount < F_H_HI);
`ifdef VGA_FB_VBLANK_ONLY_WRITE_EN
    wr.wr_ready = rst_n && !fetch && ((vcount >= V_HI) || (vcount < V_LO));
`else
    wr.wr_ready = rst_n && !fetch;
`endif
    wr_fire = wr.wr_req && wr.wr_ready;
  end

  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rd_ptr     <= '0;
      vld_pipe   <= '0;
      pixel_out  <= '0;
      frame_tick <= 1'b0;
    end else begin
      // Shift form keeps the pipe legal when it is a single stage (RAM_LAT=0).
      vld_pipe   <= (vld_pipe << 1) | PIPE_W'(fetch);
      pixel_out  <= vld_pipe[PIPE_W-1] ? mem_rdata : '0;
      frame_tick <= (vcount == V_HI) && (hcount == '0);

      if (vcount == '0)  rd_ptr <= '0;
      else if (fetch)    rd_ptr <= rd_ptr + ADDR_W'(1);

      if (fetch) begin
        mem_addr <= rd_ptr;
        mem_we   <= 1'b0;
      end else if (wr_fire) begin
        mem_addr  <= wr.wr_addr;
        mem_wdata <= wr.wr_data;
        mem_we    <= 1'b1;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter. The bench drives hcount/vcount
// directly and plays selected whole lines (skipping idle lines) so that a
// frame costs only a few thousand cycles. Expected pixels are queued at the
// fetch cycle and popped when the pixel must appear; expected writes are
// queued at acceptance and popped when mem_we shows up.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  pixel_out;
  logic        frame_tick, synced;

  vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) wr_bus ();

  vga_fb_arbiter #(
    .DATA_W(8), .ADDR_W(19), .H_START(144), .H_END(784),
    .V_START(35), .V_END(515), .RAM_LAT(1)
  ) dut (
    .vga_clock (clk),
    .rst_n     (rst_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .wr        (wr_bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pixel_out (pixel_out),
    .frame_tick(frame_tick),
    .synced    (synced)
  );

  always #5 clk = ~clk;

  // RAM model: preload pixel = addr[7:0], overridden by writes; 1-cycle read.
  logic [7:0] wmem [int];
  always @(posedge clk) begin
    mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)] : mem_addr[7:0];
    if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
  end

  typedef struct {logic [18:0] a; logic [7:0] d;} wr_t;

  logic [7:0] px_q [$];
  wr_t        wq [$];
  logic [7:0] pix [0:799];

  int n_checks = 0;
  int n_pass   = 0;

  bit   sync_exp  = 1'b0;
  bit   tick_prev = 1'b0;
  int   exp_ptr   = 0;
  int   w_left    = 0;
  int   w_addr    = 0;
  int   w_data    = 0;
  int   acc_v     = -1;
  int   acc_h     = -1;
  int   we_cnt, we_first, we_last;
  int   tick_cnt  = 0;
  int   unsync_reads = 0;
  logic [18:0] last_addr = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s v=%0d h=%0d: got 0x%0h expected 0x%0h", tag, vcount, hcount, got, exp);
  endtask

  task automatic cycle(input int h, input int v);
    bit         f_exp, rdy_exp, acc, tick_nxt;
    logic [7:0] pix_exp;
    hcount = 10'(h);
    vcount = 10'(v);
    wr_bus.wr_req  = (w_left > 0);
    wr_bus.wr_addr = 19'(w_addr);
    wr_bus.wr_data = 8'(w_data);
    if (!rst_n) begin
      sync_exp  = 1'b0;
      tick_prev = 1'b0;
      px_q.delete();
      wq.delete();
    end
    f_exp = rst_n && sync_exp && v >= 35 && v < 515 && h >= 141 && h < 781;
`ifdef VGA_FB_VBLANK_ONLY_WRITE_EN
    rdy_exp = rst_n && !f_exp && (v >= 515 || v < 35);
`else
    rdy_exp = rst_n && !f_exp;
`endif
    if (f_exp) begin
      px_q.push_back(8'(exp_ptr));
      exp_ptr++;
    end

    @(negedge clk);
    if (rst_n && sync_exp && v >= 35 && v < 515 && h >= 144 && h < 784 && px_q.size() > 0)
      pix_exp = px_q.pop_front();
    else
      pix_exp = 8'h00;
    check_val("pixel_out", 32'(pixel_out), 32'(pix_exp));
    pix[h] = pixel_out;
    check_val("wr_ready", 32'(wr_bus.wr_ready), 32'(rdy_exp));
    check_val("synced", 32'(synced), 32'(sync_exp));
    check_val("frame_tick", 32'(frame_tick), 32'(tick_prev));
    if (frame_tick) tick_cnt++;

    if (mem_we) begin
      we_cnt++;
      if (we_first < 0) we_first = h;
      we_last = h;
      check_val("we_pending", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        wr_t e;
        e = wq.pop_front();
        check_val("mem_addr_wr", 32'(mem_addr), 32'(e.a));
        check_val("mem_wdata", 32'(mem_wdata), 32'(e.d));
      end
    end
    if (rst_n && !sync_exp && !mem_we && mem_addr != last_addr) unsync_reads++;
    last_addr = mem_addr;

    acc = wr_bus.wr_req && rdy_exp;
    if (acc) begin
      wq.push_back('{a: wr_bus.wr_addr, d: wr_bus.wr_data});
      acc_v = v;
      acc_h = h;
    end
    tick_nxt = rst_n && v == 515 && h == 0;

    @(posedge clk);
    #1;
    tick_prev = tick_nxt;
    if (rst_n && v == 0) begin
      sync_exp = 1'b1;
      exp_ptr  = 0;
    end
    if (acc) begin
      w_left--;
      w_addr++;
      w_data++;
    end
  endtask

  // Plays one full line; optionally starts a write burst at inj_h and/or
  // pulses reset for three cycles starting at rst_h (-1 disables either).
  task automatic play_line(input int v, input int inj_h, input int inj_n,
                           input int inj_addr, input int inj_data, input int rst_h);
    we_cnt   = 0;
    we_first = -1;
    we_last  = -1;
    for (int h = 0; h < 800; h++) begin
      if (h == inj_h) begin
        w_left = inj_n;
        w_addr = inj_addr;
        w_data = inj_data;
      end
      if (h == rst_h) begin
        rst_n = 1'b0;
        unsync_reads = 0;
      end
      if (rst_h >= 0 && h == rst_h + 3) rst_n = 1'b1;
      cycle(h, v);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    hcount = 10'd300;
    vcount = 10'd100;
    wr_bus.wr_req  = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle(300, 100);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    unsync_reads = 0;

    // Unsynced: writer owns the port (unless vblank-only gating holds it off).
    play_line(100, 10, 1, 32'h50100, 32'h3C, -1);
    play_line(101, -1, 0, 0, 0, -1);
    play_line(515, -1, 0, 0, 0, -1);
`ifdef VGA_FB_VBLANK_ONLY_WRITE_EN
    check_val("unsync_acc_v", 32'(acc_v), 32'd515);
    check_val("unsync_acc_h", 32'(acc_h), 32'd0);
`else
    check_val("unsync_acc_v", 32'(acc_v), 32'd100);
    check_val("unsync_acc_h", 32'(acc_h), 32'd10);
`endif
    play_line(520, -1, 0, 0, 0, -1);
    play_line(0, -1, 0, 0, 0, -1);
    check_val("unsync_reads", 32'(unsync_reads), 32'd0);
    check_val("synced_after_v0", 32'(synced), 32'd1);

    play_line(35, -1, 0, 0, 0, -1);
    check_val("l35_h143", 32'(pix[143]), 32'h00);
    check_val("l35_h144", 32'(pix[144]), 32'h00);
    check_val("l35_h145", 32'(pix[145]), 32'h01);
    check_val("l35_h783", 32'(pix[783]), 32'h7F);
    check_val("l35_h784", 32'(pix[784]), 32'h00);
    play_line(36, -1, 0, 0, 0, -1);
    check_val("l36_h144", 32'(pix[144]), 32'h80);

    // Write held across the fetch window.
    play_line(40, 150, 1, 32'h12345, 32'hA5, -1);
    check_val("l40_h783", 32'(pix[783]), 32'h7F);
`ifdef VGA_FB_VBLANK_ONLY_WRITE_EN
    check_val("l40_we_cnt", 32'(we_cnt), 32'd0);
`else
    check_val("l40_we_cnt", 32'(we_cnt), 32'd1);
    check_val("l40_acc_h", 32'(acc_h), 32'd781);
`endif
    play_line(515, -1, 0, 0, 0, -1);
`ifdef VGA_FB_VBLANK_ONLY_WRITE_EN
    check_val("held_acc_v", 32'(acc_v), 32'd515);
    check_val("held_acc_h", 32'(acc_h), 32'd0);
`else
    check_val("held_acc_v", 32'(acc_v), 32'd40);
    check_val("held_acc_h", 32'(acc_h), 32'd781);
`endif

    // Back-to-back burst in vertical blanking.
    play_line(520, 0, 100, 32'h50000, 32'h00, -1);
    check_val("burst_we_cnt", 32'(we_cnt), 32'd100);
    check_val("burst_span", 32'(we_last - we_first + 1), 32'd100);
    check_val("burst_first", 32'(we_first), 32'd1);
    check_val("wq_drained", 32'(wq.size()), 32'd0);

    // Second frame with a mid-line reset on an active line.
    play_line(0, -1, 0, 0, 0, -1);
    play_line(35, -1, 0, 0, 0, -1);
    play_line(100, -1, 0, 0, 0, 300);
    check_val("post_rst_pix", 32'(pix[500]), 32'h00);
    play_line(515, -1, 0, 0, 0, -1);
    check_val("post_rst_synced", 32'(synced), 32'd0);
    play_line(0, -1, 0, 0, 0, -1);
    check_val("post_rst_unsync_reads", 32'(unsync_reads), 32'd0);
    check_val("resynced", 32'(synced), 32'd1);
    play_line(35, -1, 0, 0, 0, -1);
    check_val("f3_l35_h145", 32'(pix[145]), 32'h01);
    check_val("f3_l35_h783", 32'(pix[783]), 32'h7F);
    play_line(515, -1, 0, 0, 0, -1);
    check_val("tick_count", 32'(tick_cnt), 32'd4);
    check_val("px_q_drained", 32'(px_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (640x480, 8-bit pixels) between two requesters: display scanout and the drawing/game-logic writer.
- Sits between the VGA timing counters (hcount/vcount) and the framebuffer RAM.
- Scanout has absolute priority during the prefetch window. The writer is served through a valid/ready port in all other cycles.
- Produces a pixel stream aligned to the timing counters, plus a once-per-frame tick for game logic.

Parameters:
- DATA_W, 8, pixel width.
- ADDR_W, 19, RAM address width; must cover 307200 words.
- H_START, 144, first active hcount.
- H_END, 784, first hcount after the active area.
- V_START, 35, first active vcount.
- V_END, 515, first vcount after the active area.
- RAM_LAT, 1, RAM read latency in cycles, measured from a registered address to valid mem_rdata.
- Derived localparam LEAD = RAM_LAT+2.

Ports:
- vga_clock  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hcount  in  10  current pixel column from timing generator.
- vcount  in  10  current line from timing generator.
- wr_req  in  1  writer has a write pending.
- wr_ready  out  1  port free this cycle; combinational.
- wr_addr  in  ADDR_W  writer linear address (y*640+x).
- wr_data  in  DATA_W  writer pixel.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_we  out  1  registered RAM write enable.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- pixel_out  out  DATA_W  registered pixel to the DAC/colour mapper.
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking.
- synced  out  1  high once scanout is frame-aligned.

Behaviour:
- Reset (rst_n low, async) forces:
  - mem_addr=0, mem_we=0, mem_wdata=0, pixel_out=0, frame_tick=0, synced=0.
  - Read pointer rd_ptr=0, valid pipeline cleared.
  - wr_ready is 0 while rst_n is low.
- Fetch condition F is evaluated on the inputs: F = synced && vcount in [V_START,V_END) && hcount in [H_START-LEAD, H_END-LEAD).
- On an edge where F=1:
  - mem_addr<=rd_ptr, mem_we<=0, rd_ptr<=rd_ptr+1.
  - Exactly 640 fetches per active line and 307200 per frame.
- wr_ready = rst_n && !F.
- On an edge where wr_req && wr_ready:
  - mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1.
  - The write is accepted. The writer may present a new request in the next cycle, so back-to-back writes run at one per cycle.
- On an edge with neither a fetch nor an accepted write: mem_we<=0, mem_addr holds.
- Priority:
  - A fetch never yields to the writer.
  - wr_req held high during F waits with no loss; wr_addr/wr_data must stay stable until accepted.
- Valid pipeline: a LEAD-1 deep shift register carries F. At the edge where its tail is 1, pixel_out<=mem_rdata; otherwise pixel_out<=0.
- Alignment: the fetch issued at hcount=H_START-LEAD+x appears on pixel_out during the cycle hcount==H_START+x.
  - pixel_out is nonzero-capable only while hcount is in [H_START,H_END) on active lines.
  - Blanking output is 0.
- rd_ptr zeroing: rd_ptr<=0 on any edge with vcount==0. This takes precedence over increment; it cannot coincide with F.
- Sync state machine, states UNSYNC and SYNC:
  - Reset enters UNSYNC.
  - UNSYNC->SYNC on the first edge with vcount==0; synced=1 from the next cycle.
  - SYNC stays until reset.
  - In UNSYNC, F=0: no fetches, pixel_out=0, and the writer owns the port every cycle.
- Reset mid-frame: same as reset. No partial frame is scanned out; display resumes at the next vcount==0.
- frame_tick is registered and high for exactly one cycle after the edge where vcount==V_END && hcount==0. It is 1 once per 525-line frame regardless of synced.
- Wrap: rd_ptr wraps naturally at 2^ADDR_W. In normal operation it never exceeds 307199 before re-zeroing.

Optional Feature:
- Macro VGA_FB_VBLANK_ONLY_WRITE_EN.
- Defined:
  - wr_ready = rst_n && !F && (vcount >= V_END || vcount < V_START).
  - Writes land only in vertical blanking, for tear-free drawing.
  - A request pending at V_START stalls until V_END.
- Undefined: wr_ready as specified in Behaviour, so horizontal blanking is also usable for writes.

Test Plan:
- Reset mid-line at vcount=100, then release -> synced=0, pixel_out=0, and no mem_we=0 reads issued until vcount wraps to 0; synced=1 one cycle after the vcount==0 edge.
- Preload RAM with pixel = addr[7:0], run one full frame -> on line vcount=35, pixel_out at hcount 144,145,783 equals 0x00,0x01,0x7F (addr 639); on line 36 at hcount 144 equals 0x80 (addr 640); pixel_out=0 at hcount 143 and 784.
- Hold wr_req=1 at addr 0x12345, data 0xA5, starting at vcount=40, hcount=150 (inside F) -> wr_ready=0 until hcount=781 (H_END-LEAD); one mem_we=1 cycle with mem_addr=0x12345, mem_wdata=0xA5; no fetch is skipped (640 fetches counted on that line).
- Stream 100 writes back-to-back during vcount=520 -> 100 consecutive mem_we=1 cycles with sequential addresses and no duplicates or drops.
- Count frame_tick over 3 frames -> exactly 3 pulses, each in the cycle after the edge with vcount=515, hcount=0.
- With VGA_FB_VBLANK_ONLY_WRITE_EN, wr_req at vcount=100, hcount=10 -> wr_ready stays 0 until vcount=515; write commits there.
